// File: rtl/avg_unpool_if.sv
// rtl/avg_unpool_if.sv - stream and status signals of the 2x2 un-pooling block
interface avg_unpool_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    // Producer/consumer side: feeds the pooled map, drains the un-pooled map
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    // Block side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/avg_unpool.sv
// rtl/avg_unpool.sv - streaming FP16 2x2 un-pooling; AVG_UNPOOL_SCALE_EN adds the x0.25 scale
module avg_unpool #(
    parameter int IN_W = 14,
    parameter int IN_H = 14
) (
    input  logic       clk,
    input  logic       rst,
    avg_unpool_if.slave bus
);
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

    typedef enum logic {
        ROW_A,
        ROW_B
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          dup_q, dup_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          busy_q, busy_d;

    logic [15:0]   buf_q [IN_W];
    logic          buf_we;
    logic [CW-1:0] buf_waddr;
    logic [CW-1:0] col_inc;
    logic [15:0]   scaled;
    logic          in_ready;
    logic          in_accept;
    logic          out_hs;

`ifdef AVG_UNPOOL_SCALE_EN
    // Exact FP16 multiply by 0.25 (constant 16'h3400): exponent drops by two,
    // results that fall below the normal range round to nearest-even.
    function automatic logic [15:0] float_mult_quarter(input logic [15:0] x);
        logic [4:0]  e;
        logic [10:0] sig;
        logic [10:0] q;
        logic        rb;
        logic        st;
        e = x[14:10];
        if (e == 5'd31) begin
            return x;
        end
        if (e >= 5'd3) begin
            return {x[15], e - 5'd2, x[9:0]};
        end
        sig = (e == 5'd0) ? {1'b0, x[9:0]} : {1'b1, x[9:0]};
        if (e == 5'd2) begin
            q  = sig >> 1;
            rb = sig[0];
            st = 1'b0;
        end else begin
            q  = sig >> 2;
            rb = sig[1];
            st = sig[0];
        end
        if (rb && (st || q[0])) begin
            q = q + 11'd1;
        end
        // a carry into bit 10 lands in the exponent field, giving the smallest normal
        return {x[15], 4'b0000, q};
    endfunction

    assign scaled = float_mult_quarter(bus.in_data);
`else
    assign scaled = bus.in_data;
`endif

    assign col_inc   = col_q + CW'(1);
    // A new element may only follow the second copy of a non-final column of ROW_A
    assign in_ready  = !rst && (state_q == ROW_A) &&
                       (!out_valid_q || (bus.out_ready && dup_q && (col_q != COL_LAST)));
    assign in_accept = bus.in_valid && in_ready;
    assign out_hs    = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.out_last  = out_valid_q && (state_q == ROW_B) && (row_q == ROW_LAST) &&
                           (col_q == COL_LAST) && dup_q;

    // Next-state logic for the row/copy sequencer and the output register
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        dup_d       = dup_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        buf_we      = 1'b0;
        buf_waddr   = col_q;
        case (state_q)
            ROW_A: begin
                if (out_hs) begin
                    if (!dup_q) begin
                        dup_d = 1'b1;
                    end else if (col_q == COL_LAST) begin
                        state_d    = ROW_B;
                        col_d      = '0;
                        dup_d      = 1'b0;
                        out_data_d = buf_q[0];
                    end else begin
                        col_d       = col_inc;
                        out_valid_d = 1'b0;
                    end
                end
                // col_d already points at the slot for a back-to-back element
                if (in_accept) begin
                    buf_we      = 1'b1;
                    buf_waddr   = col_d;
                    out_data_d  = scaled;
                    out_valid_d = 1'b1;
                    dup_d       = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ROW_B: begin
                if (out_hs) begin
                    if (!dup_q) begin
                        dup_d = 1'b1;
                    end else if (col_q == COL_LAST) begin
                        state_d     = ROW_A;
                        col_d       = '0;
                        dup_d       = 1'b0;
                        out_valid_d = 1'b0;
                        if (row_q == ROW_LAST) begin
                            row_d  = '0;
                            busy_d = 1'b0;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d      = col_inc;
                        dup_d      = 1'b0;
                        out_data_d = buf_q[col_inc];
                    end
                end
            end
            default: begin
                state_d = ROW_A;
            end
        endcase
    end

    // Sequencer and output registers; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ROW_A;
            col_q       <= '0;
            row_q       <= '0;
            dup_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dup_q       <= dup_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    // Row buffer holds the already-scaled row for the ROW_B replay
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_waddr] <= scaled;
        end
    end
endmodule

// File: tb/tb_avg_unpool.sv
// tb/tb_avg_unpool.sv - directed table-driven bench for avg_unpool
module tb_avg_unpool;
`ifdef AVG_UNPOOL_SCALE_EN
    localparam logic [15:0] S3C = 16'h3400, S40 = 16'h3800, S42 = 16'h3A00, S44 = 16'h3C00;
    localparam logic [15:0] S45 = 16'h3D00, S46 = 16'h3E00, S47 = 16'h3F00;
    localparam logic [15:0] S48 = 16'h4000, S49 = 16'h4100, S4A = 16'h4200;
`else
    localparam logic [15:0] S3C = 16'h3C00, S40 = 16'h4000, S42 = 16'h4200, S44 = 16'h4400;
    localparam logic [15:0] S45 = 16'h4500, S46 = 16'h4600, S47 = 16'h4700;
    localparam logic [15:0] S48 = 16'h4800, S49 = 16'h4900, S4A = 16'h4A00;
`endif

    logic        clk;
    logic        rst;
    int          sel;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        o_valid, o_in_ready, o_last, o_busy;
    logic [15:0] o_data;
    int          n_cmp;
    int          n_bad;

    avg_unpool_if ifa ();
    avg_unpool_if ifb ();

    assign ifa.in_valid  = in_valid && (sel == 0);
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid && (sel == 1);
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;

    assign o_valid    = (sel == 1) ? ifb.out_valid : ifa.out_valid;
    assign o_in_ready = (sel == 1) ? ifb.in_ready  : ifa.in_ready;
    assign o_last     = (sel == 1) ? ifb.out_last  : ifa.out_last;
    assign o_busy     = (sel == 1) ? ifb.busy      : ifa.busy;
    assign o_data     = (sel == 1) ? ifb.out_data  : ifa.out_data;

    avg_unpool #(.IN_W(2), .IN_H(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    avg_unpool #(.IN_W(3), .IN_H(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din  [4];
        logic [15:0] dexp [4];
        int          rmode;
        int          vmode;
        int          abort_at;
        string       nm;
    } vec_t;

    vec_t vt [5];

    function automatic vec_t mkvec(input logic [15:0] a, b, c, d,
                                   input logic [15:0] ea, eb, ec, ed,
                                   input int r, v, ab, input string nm);
        vec_t t;
        t.din[0] = a;  t.din[1] = b;  t.din[2] = c;  t.din[3] = d;
        t.dexp[0] = ea; t.dexp[1] = eb; t.dexp[2] = ec; t.dexp[3] = ed;
        t.rmode = r; t.vmode = v; t.abort_at = ab; t.nm = nm;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // rmode 1: out_ready toggles; vmode 1: in_valid offered one cycle in five
    task automatic run(input int sel_i, input logic [15:0] din[$], input logic [15:0] dexp[$],
                       input int w, input int h, input int rmode, input int vmode,
                       input int abort_at, input string nm);
        int          ii, no, cyc, target, flen, pos;
        int          stab_err, rdyb_err, low_run, max_low;
        logic        started, prev_hold;
        logic [15:0] prev_data;
        logic [15:0] got_d[$];
        logic        got_l[$];
        ii = 0; no = 0; cyc = 0; stab_err = 0; rdyb_err = 0; low_run = 0; max_low = 0;
        started = 1'b0; prev_hold = 1'b0; prev_data = '0;
        flen   = 4 * w * h;
        target = (abort_at > 0) ? abort_at : din.size() * 4;
        sel    = sel_i;
        while (no < target && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            out_ready = (rmode == 1) ? ((cyc % 2) == 0) : 1'b1;
            in_valid  = (ii < din.size()) && (vmode == 0 || (cyc % 5) == 0);
            in_data   = in_valid ? din[ii] : 16'hDEAD;
            #1;
            if (prev_hold && (o_data !== prev_data || o_valid !== 1'b1)) stab_err++;
            pos = no % (4 * w);
            if (o_valid && pos >= 2 * w && o_in_ready) rdyb_err++;
            if (started) begin
                if (!o_busy) begin
                    low_run++;
                    if (low_run > max_low) max_low = low_run;
                end else begin
                    low_run = 0;
                end
            end
            if (in_valid && o_in_ready) begin
                ii++;
                started = 1'b1;
            end
            if (o_valid && out_ready) begin
                got_d.push_back(o_data);
                got_l.push_back(o_last);
                no++;
            end
            prev_hold = o_valid && !out_ready;
            prev_data = o_data;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_count"}, no, target);
        for (int k = 0; k < no; k++) begin
            int f, kk, idx;
            f   = k / flen;
            kk  = k % flen;
            idx = f * w * h + ((kk / (2 * w)) / 2) * w + (kk % (2 * w)) / 2;
            chk($sformatf("%s_data%0d", nm, k), got_d[k], dexp[idx]);
            chk($sformatf("%s_last%0d", nm, k), got_l[k], (kk == flen - 1) && (abort_at == 0));
        end
        chk({nm, "_hold"}, stab_err, 0);
        chk({nm, "_rdy_rowb"}, rdyb_err, 0);
        if (abort_at > 0) begin
            rst = 1'b1;
            #1;
            chk({nm, "_rst_valid"}, o_valid, 0);
            chk({nm, "_rst_busy"}, o_busy, 0);
            chk({nm, "_rst_inrdy"}, o_in_ready, 0);
            chk({nm, "_rst_data"}, o_data, 16'h0000);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            chk({nm, "_busy_end"}, o_busy, 0);
            if (sel_i == 1) chk({nm, "_busy_gap"}, max_low <= 1, 1);
        end
    endtask

    initial begin
        logic [15:0] qd[$];
        logic [15:0] qe[$];
        n_cmp = 0; n_bad = 0;
        sel = 0; rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;

        vt[0] = mkvec(16'h3C00, 16'h4000, 16'h4200, 16'h4400, S3C, S40, S42, S44, 0, 0, 0, "nearest");
        vt[1] = mkvec(16'h3C00, 16'h4000, 16'h4200, 16'h4400, S3C, S40, S42, S44, 1, 0, 0, "bp");
        vt[2] = mkvec(16'h3C00, 16'h4000, 16'h4200, 16'h4400, S3C, S40, S42, S44, 0, 1, 0, "starve");
        vt[3] = mkvec(16'h3C00, 16'h4000, 16'h4200, 16'h4400, S3C, S40, S42, S44, 0, 0, 6, "abort");
        vt[4] = mkvec(16'h4400, 16'h4200, 16'h4000, 16'h3C00, S44, S42, S40, S3C, 0, 0, 0, "after_rst");

        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", o_valid, 0);
        chk("reset_out_data", o_data, 16'h0000);
        chk("reset_out_last", o_last, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_in_ready", o_in_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            qd = {};
            qe = {};
            for (int j = 0; j < 4; j++) begin
                qd.push_back(vt[i].din[j]);
                qe.push_back(vt[i].dexp[j]);
            end
            run(0, qd, qe, 2, 2, vt[i].rmode, vt[i].vmode, vt[i].abort_at, vt[i].nm);
        end

        qd = {16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4900, 16'h4A00};
        qe = {S45, S46, S47, S48, S49, S4A};
        run(1, qd, qe, 3, 1, 0, 0, 0, "b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
